ex_mem_pipe: RTL and testbench

//   Parametrised EX->MEM pipeline register for the CPU core. Carries register

---
 rtl/ex_mem_if.sv | 63 ++++++
 rtl/ex_mem_pipe.sv | 98 +++++++++
 tb/tb_ex_mem_pipe.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_mem_if
// Brief    : EX->MEM pipeline bus: stage control, EX fields, MEM fields and
//            the multi-cycle feedback path back into EX.
// Revision : 1.0
// ============================================================================
interface ex_mem_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 16
);
    logic                  stall_ex;
    logic                  stall_mem;
    logic                  flush;

    logic                  ex_valid;
    logic [ADDR_W-1:0]     ex_wd;
    logic                  ex_wreg;
    logic [DATA_W-1:0]     ex_wdata;
    logic                  ex_whilo;
    logic [DATA_W-1:0]     ex_hi;
    logic [DATA_W-1:0]     ex_lo;
    logic [ALUOP_W-1:0]    ex_aluop;
    logic [DATA_W-1:0]     ex_mem_addr;
    logic [DATA_W-1:0]     ex_reg2;
    logic [2*DATA_W-1:0]   hilo_temp_i;
    logic [CNT_W-1:0]      cnt_i;

    logic                  mem_valid;
    logic [ADDR_W-1:0]     mem_wd;
    logic                  mem_wreg;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_whilo;
    logic [DATA_W-1:0]     mem_hi;
    logic [DATA_W-1:0]     mem_lo;
    logic [ALUOP_W-1:0]    mem_aluop;
    logic [DATA_W-1:0]     mem_mem_addr;
    logic [DATA_W-1:0]     mem_reg2;
    logic [2*DATA_W-1:0]   hilo_temp_o;
    logic [CNT_W-1:0]      cnt_o;
    logic [PERF_W-1:0]     bubble_cnt;

    modport master (
        output stall_ex, stall_mem, flush,
        output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
        output ex_aluop, ex_mem_addr, ex_reg2, hilo_temp_i, cnt_i,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
        input  mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o, bubble_cnt
    );

    modport slave (
        input  stall_ex, stall_mem, flush,
        input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
        input  ex_aluop, ex_mem_addr, ex_reg2, hilo_temp_i, cnt_i,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
        output mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_mem_pipe
// Brief    : EX->MEM pipeline register with stall/flush, multi-cycle feedback
//            hold and a saturating bubble counter.
// Revision : 1.0
// ============================================================================
module ex_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    ex_mem_if.slave   bus
);
    typedef struct packed {
        logic                valid;
        logic [ADDR_W-1:0]   wd;
        logic                wreg;
        logic [DATA_W-1:0]   wdata;
        logic                whilo;
        logic [DATA_W-1:0]   hi;
        logic [DATA_W-1:0]   lo;
        logic [ALUOP_W-1:0]  aluop;
        logic [DATA_W-1:0]   mem_addr;
        logic [DATA_W-1:0]   reg2;
    } stage_t;

    localparam logic [PERF_W-1:0] c_bub_max = '1;
    localparam logic [PERF_W-1:0] c_bub_one = {{(PERF_W-1){1'b0}}, 1'b1};

    stage_t                r_stage;
    stage_t                w_capture;
    logic [2*DATA_W-1:0]   r_hilo;
    logic [CNT_W-1:0]      r_cnt;
    logic [PERF_W-1:0]     r_bubble;

    // Write enables of an invalid EX slot must never reach MEM.
    always_comb begin
        w_capture          = '0;
        w_capture.valid    = bus.ex_valid;
        w_capture.wd       = bus.ex_wd;
        w_capture.wreg     = bus.ex_wreg & bus.ex_valid;
        w_capture.wdata    = bus.ex_wdata;
        w_capture.whilo    = bus.ex_whilo & bus.ex_valid;
        w_capture.hi       = bus.ex_hi;
        w_capture.lo       = bus.ex_lo;
        w_capture.aluop    = bus.ex_aluop;
        w_capture.mem_addr = bus.ex_mem_addr;
        w_capture.reg2     = bus.ex_reg2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage  <= '0;
            r_hilo   <= '0;
            r_cnt    <= '0;
            r_bubble <= '0;
        end else if (bus.flush) begin
            r_stage  <= '0;
            r_hilo   <= '0;
            r_cnt    <= '0;
        end else if (bus.stall_mem) begin
            // MEM blocked: everything holds, whatever EX claims.
            r_stage  <= r_stage;
        end else if (bus.stall_ex) begin
            r_stage  <= '0;
            r_hilo   <= bus.hilo_temp_i;
            r_cnt    <= bus.cnt_i;
            if (r_bubble != c_bub_max) begin
                r_bubble <= r_bubble + c_bub_one;
            end
        end else begin
            r_stage  <= w_capture;
            r_hilo   <= '0;
            r_cnt    <= '0;
        end
    end

    assign bus.mem_valid    = r_stage.valid;
    assign bus.mem_wd       = r_stage.wd;
    assign bus.mem_wreg     = r_stage.wreg;
    assign bus.mem_wdata    = r_stage.wdata;
    assign bus.mem_whilo    = r_stage.whilo;
    assign bus.mem_hi       = r_stage.hi;
    assign bus.mem_lo       = r_stage.lo;
    assign bus.mem_aluop    = r_stage.aluop;
    assign bus.mem_mem_addr = r_stage.mem_addr;
    assign bus.mem_reg2     = r_stage.reg2;
    assign bus.hilo_temp_o  = r_hilo;
    assign bus.cnt_o        = r_cnt;
    assign bus.bubble_cnt   = r_bubble;
endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_pipe
// Brief    : Directed bench for ex_mem_pipe; a wide-counter and a 2-bit-counter
//            instance share one stimulus stream and one reference model.
// Revision : 1.0
// ============================================================================
module tb_ex_mem_pipe;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ex_mem_if #(.DATA_W(DW), .ADDR_W(AW), .ALUOP_W(OW), .CNT_W(CW), .PERF_W(16)) u_if ();
    ex_mem_if #(.DATA_W(DW), .ADDR_W(AW), .ALUOP_W(OW), .CNT_W(CW), .PERF_W(2))  s_if ();

    assign s_if.stall_ex    = u_if.stall_ex;
    assign s_if.stall_mem   = u_if.stall_mem;
    assign s_if.flush       = u_if.flush;
    assign s_if.ex_valid    = u_if.ex_valid;
    assign s_if.ex_wd       = u_if.ex_wd;
    assign s_if.ex_wreg     = u_if.ex_wreg;
    assign s_if.ex_wdata    = u_if.ex_wdata;
    assign s_if.ex_whilo    = u_if.ex_whilo;
    assign s_if.ex_hi       = u_if.ex_hi;
    assign s_if.ex_lo       = u_if.ex_lo;
    assign s_if.ex_aluop    = u_if.ex_aluop;
    assign s_if.ex_mem_addr = u_if.ex_mem_addr;
    assign s_if.ex_reg2     = u_if.ex_reg2;
    assign s_if.hilo_temp_i = u_if.hilo_temp_i;
    assign s_if.cnt_i       = u_if.cnt_i;

    ex_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .ALUOP_W(OW), .CNT_W(CW), .PERF_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    ex_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .ALUOP_W(OW), .CNT_W(CW), .PERF_W(2)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    // Reference: the instruction sitting in MEM, the value fed back to EX,
    // and the unbounded number of bubbles inserted so far.
    typedef struct packed {
        logic           valid;
        logic [AW-1:0]  wd;
        logic           wreg;
        logic [DW-1:0]  wdata;
        logic           whilo;
        logic [DW-1:0]  hi;
        logic [DW-1:0]  lo;
        logic [OW-1:0]  aluop;
        logic [DW-1:0]  mem_addr;
        logic [DW-1:0]  reg2;
    } ref_t;

    ref_t           m_stage   = '0;
    logic [2*DW-1:0] m_hilo   = '0;
    logic [CW-1:0]  m_cnt     = '0;
    int             m_bubbles = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_stage <= '0; m_hilo <= '0; m_cnt <= '0; m_bubbles <= 0;
        end else if (u_if.flush) begin
            m_stage <= '0; m_hilo <= '0; m_cnt <= '0;
        end else if (!u_if.stall_mem) begin
            if (u_if.stall_ex) begin
                m_stage   <= '0;
                m_hilo    <= u_if.hilo_temp_i;
                m_cnt     <= u_if.cnt_i;
                m_bubbles <= m_bubbles + 1;
            end else begin
                m_stage <= {u_if.ex_valid, u_if.ex_wd, u_if.ex_wreg & u_if.ex_valid,
                            u_if.ex_wdata, u_if.ex_whilo & u_if.ex_valid, u_if.ex_hi,
                            u_if.ex_lo, u_if.ex_aluop, u_if.ex_mem_addr, u_if.ex_reg2};
                m_hilo  <= '0;
                m_cnt   <= '0;
            end
        end
    end

    logic [$bits(ref_t)-1:0] u_act;
    logic [$bits(ref_t)-1:0] s_act;
    assign u_act = {u_if.mem_valid, u_if.mem_wd, u_if.mem_wreg, u_if.mem_wdata, u_if.mem_whilo,
                    u_if.mem_hi, u_if.mem_lo, u_if.mem_aluop, u_if.mem_mem_addr, u_if.mem_reg2};
    assign s_act = {s_if.mem_valid, s_if.mem_wd, s_if.mem_wreg, s_if.mem_wdata, s_if.mem_whilo,
                    s_if.mem_hi, s_if.mem_lo, s_if.mem_aluop, s_if.mem_mem_addr, s_if.mem_reg2};

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("model_stage",     u_act, m_stage);
            chk("model_stage_s",   s_act, m_stage);
            chk("model_fb",        {u_if.hilo_temp_o, u_if.cnt_o}, {m_hilo, m_cnt});
            chk("model_fb_s",      {s_if.hilo_temp_o, s_if.cnt_o}, {m_hilo, m_cnt});
            chk("model_bubble",    u_if.bubble_cnt, sat(m_bubbles, 16));
            chk("model_bubble_s",  s_if.bubble_cnt, sat(m_bubbles, 2));
        end
    end

    // Apply one vector; on return the outputs reflect the edge that took it.
    task automatic cyc(input logic fl, input logic sm, input logic se, input logic v,
                       input logic wreg, input logic [AW-1:0] wd, input logic [DW-1:0] wdata,
                       input logic [2*DW-1:0] ht, input logic [CW-1:0] cn);
        u_if.flush       = fl;
        u_if.stall_mem   = sm;
        u_if.stall_ex    = se;
        u_if.ex_valid    = v;
        u_if.ex_wreg     = wreg;
        u_if.ex_wd       = wd;
        u_if.ex_wdata    = wdata;
        u_if.ex_whilo    = 1'b1;
        u_if.ex_hi       = wdata ^ 32'hA5A5_5A5A;
        u_if.ex_lo       = ~wdata;
        u_if.ex_aluop    = wdata[7:0] + 8'd1;
        u_if.ex_mem_addr = wdata + 32'd4;
        u_if.ex_reg2     = {wdata[15:0], wdata[31:16]};
        u_if.hilo_temp_i = ht;
        u_if.cnt_i       = cn;
        @(negedge clk);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        chk("reset_bubble", u_if.bubble_cnt, 0);
        chk("reset_valid",  u_if.mem_valid, 0);

        // Four bubbles: the 2-bit counter saturates, the wide one keeps going.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 1, 1, 5'd7, 32'h11 + i, 64'h10 + i, 2'(i));
            chk("sat_bubble_s", s_if.bubble_cnt, (i < 3) ? i + 1 : 3);
            chk("wide_bubble",  u_if.bubble_cnt, i + 1);
        end

        cyc(0, 0, 0, 1, 1, 5'd5, 32'h1234, 64'h0, 2'd0);
        chk("adv_wd",    u_if.mem_wd, 5);
        chk("adv_wreg",  u_if.mem_wreg, 1);
        chk("adv_wdata", u_if.mem_wdata, 32'h1234);
        chk("adv_valid", u_if.mem_valid, 1);

        cyc(0, 0, 1, 1, 1, 5'd9, 32'h5555, 64'h0000_0001_FFFF_FFFF, 2'd1);
        chk("bub_hilo",   u_if.hilo_temp_o, 64'h0000_0001_FFFF_FFFF);
        chk("bub_cnt",    u_if.cnt_o, 1);
        chk("bub_valid",  u_if.mem_valid, 0);
        chk("bub_wdata",  u_if.mem_wdata, 0);
        chk("bub_bubble", u_if.bubble_cnt, 5);
        cyc(0, 0, 0, 1, 1, 5'd6, 32'h77, 64'hABCD, 2'd3);
        chk("rel_hilo",  u_if.hilo_temp_o, 0);
        chk("rel_cnt",   u_if.cnt_o, 0);
        chk("rel_wdata", u_if.mem_wdata, 32'h77);

        // MEM stall with EX changing, including stall_mem without stall_ex.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1'(i), 1, 1, 5'(20 + i), 32'h900 + i, 64'h3 + i, 2'd2);
            chk("hold_wdata",  u_if.mem_wdata, 32'h77);
            chk("hold_wd",     u_if.mem_wd, 6);
            chk("hold_bubble", u_if.bubble_cnt, 5);
        end
        cyc(0, 0, 1, 1, 1, 5'd1, 32'h1, 64'hCAFE_0000_1234_5678, 2'd2);
        cyc(0, 1, 1, 1, 1, 5'd2, 32'h2, 64'h1111, 2'd1);
        chk("hold_hilo",   u_if.hilo_temp_o, 64'hCAFE_0000_1234_5678);
        chk("hold_cnt",    u_if.cnt_o, 2);
        chk("hold_bub2",   u_if.bubble_cnt, 6);

        cyc(1, 1, 1, 1, 1, 5'd3, 32'h3, 64'h2222, 2'd3);
        chk("flush_valid",  u_if.mem_valid, 0);
        chk("flush_hilo",   u_if.hilo_temp_o, 0);
        chk("flush_bubble", u_if.bubble_cnt, 6);

        cyc(0, 0, 0, 0, 1, 5'd12, 32'hBEEF, 64'h0, 2'd0);
        chk("inv_wreg",  u_if.mem_wreg, 0);
        chk("inv_whilo", u_if.mem_whilo, 0);
        chk("inv_valid", u_if.mem_valid, 0);
        chk("inv_wdata", u_if.mem_wdata, 32'hBEEF);

        cyc(0, 0, 0, 1, 1, 5'd3, 32'hDEAD_BEEF, 64'h0, 2'd0);
        chk("pre_rst_wdata", u_if.mem_wdata, 32'hDEAD_BEEF);
        cyc(0, 0, 1, 1, 1, 5'd3, 32'h0, 64'h1357, 2'd3);
        cyc(0, 0, 0, 1, 1, 5'd3, 32'hDEAD_BEEF, 64'h0, 2'd0);
        u_if.stall_ex = 1'b1;
        u_if.hilo_temp_i = 64'h2468;
        #2 rst = 1'b0;
        #1;
        chk("rst_async",   {u_act, u_if.hilo_temp_o, u_if.cnt_o, u_if.bubble_cnt}, 0);
        chk("rst_async_s", {s_act, s_if.hilo_temp_o, s_if.cnt_o, s_if.bubble_cnt}, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 0, 1, 1, 5'd4, 32'h4444, 64'h0, 2'd0);
        chk("post_rst_wd",     u_if.mem_wd, 4);
        chk("post_rst_bubble", u_if.bubble_cnt, 0);
        cyc(0, 0, 0, 1, 0, 5'd0, 32'h0, 64'h0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
